// File: rtl/sha_msg_sched.sv
// SHA-256/384/512 message schedule: loads one 16-word block, then streams W_t with round index.
// Output register holds W_t under backpressure; one W_t per cycle when wt_ready stays high.
module sha_msg_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hash_size,
  input  logic        start,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [63:0] blk_word,
  output logic        wt_valid,
  input  logic        wt_ready,
  output logic [63:0] wt_out,
  output logic [6:0]  cnt,
  output logic        busy,
  output logic        done
);

  localparam int NWORDS = 16;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t      state_q;
  logic        hs_q;
  logic [3:0]  ld_idx_q;
  logic        blk_ready_q;
  logic        wt_valid_q;
  logic [63:0] wt_out_q;
  logic [6:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] sched_q [NWORDS];

  function automatic logic [31:0] sig0_32(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_32(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_64(input logic [63:0] x);
    return ((x >> 1) | (x << 63)) ^ ((x >> 8) | (x << 56)) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_64(input logic [63:0] x);
    return ((x >> 19) | (x << 45)) ^ ((x >> 61) | (x << 3)) ^ (x >> 6);
  endfunction

  logic        load_hs;
  logic        exp_hs;
  logic [6:0]  last_idx;
  logic [6:0]  t_nxt;
  logic [3:0]  i_nxt;
  logic [63:0] w2, w7, w15, w16, w_nxt;

  assign load_hs  = (state_q == LOAD) && blk_valid && blk_ready_q;
  assign exp_hs   = (state_q == EXPAND) && wt_valid_q && wt_ready;
  assign last_idx = hs_q ? 7'd79 : 7'd63;

  // Circular buffer: entry t mod 16 holds W_{t-16} until W_t replaces it.
  always_comb begin
    t_nxt = cnt_q + 7'd1;
    i_nxt = t_nxt[3:0];
    w2    = sched_q[i_nxt - 4'd2];
    w7    = sched_q[i_nxt - 4'd7];
    w15   = sched_q[i_nxt - 4'd15];
    w16   = sched_q[i_nxt];
    if (t_nxt < 7'd16) begin
      w_nxt = w16;
    end else if (hs_q) begin
      w_nxt = sig1_64(w2) + w7 + sig0_64(w15) + w16;
    end else begin
      w_nxt = {32'd0, sig1_32(w2[31:0]) + w7[31:0] + sig0_32(w15[31:0]) + w16[31:0]};
    end
  end

  logic        sched_we;
  logic [3:0]  sched_wa;
  logic [63:0] sched_wd;

  always_comb begin
    sched_we = 1'b0;
    sched_wa = ld_idx_q;
    sched_wd = hs_q ? blk_word : {32'd0, blk_word[31:0]};
    if (load_hs) begin
      sched_we = 1'b1;
    end else if (exp_hs && (cnt_q != last_idx)) begin
      sched_we = 1'b1;
      sched_wa = i_nxt;
      sched_wd = w_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (sched_we) sched_q[sched_wa] <= sched_wd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      hs_q        <= 1'b0;
      ld_idx_q    <= 4'd0;
      blk_ready_q <= 1'b0;
      wt_valid_q  <= 1'b0;
      wt_out_q    <= 64'd0;
      cnt_q       <= 7'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hs_q        <= hash_size;
            ld_idx_q    <= 4'd0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (load_hs) begin
            ld_idx_q <= ld_idx_q + 4'd1;
            if (ld_idx_q == 4'd15) begin
              // W_0 was written on the first handshake, so it is already in the buffer.
              blk_ready_q <= 1'b0;
              wt_valid_q  <= 1'b1;
              wt_out_q    <= sched_q[0];
              cnt_q       <= 7'd0;
              state_q     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (exp_hs) begin
            if (cnt_q == last_idx) begin
              wt_valid_q <= 1'b0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              wt_out_q <= w_nxt;
              cnt_q    <= t_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_ready = blk_ready_q;
  assign wt_valid  = wt_valid_q;
  assign wt_out    = wt_out_q;
  assign cnt       = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Bench for sha_msg_sched: directed and random blocks checked against an array-based schedule model.
module tb_sha_msg_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hash_size;
  logic        start;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] blk_word;
  logic        wt_valid;
  logic        wt_ready;
  logic [63:0] wt_out;
  logic [6:0]  cnt;
  logic        busy;
  logic        done;

  sha_msg_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .hash_size (hash_size),
    .start     (start),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .wt_out    (wt_out),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] msg     [16];
  logic [63:0] exp_w   [80];
  logic [63:0] known_w [80];
  bit          known_v [80];

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, idx, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int bits);
    if (bits == 64) return (x >> n) | (x << (64 - n));
    return ((x >> n) | (x << (32 - n))) & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input logic hs);
    if (hs) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input logic hs);
    if (hs) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
  endfunction

  // Straight-line schedule over the full 80-entry array.
  task automatic compute_model(input logic hs);
    logic [63:0] mask;
    mask = hs ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t] & mask;
    for (int t = 16; t < 80; t++)
      exp_w[t] = (s1(exp_w[t-2], hs) + exp_w[t-7] + s0(exp_w[t-15], hs) + exp_w[t-16]) & mask;
  endtask

  task automatic clear_block();
    for (int i = 0; i < 16; i++) msg[i] = 64'd0;
    for (int i = 0; i < 80; i++) known_v[i] = 1'b0;
  endtask

  task automatic load_block(input logic hs, input bit skip_start);
    if (!skip_start) begin
      hash_size = hs;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    hash_size = ~hs;
    chk("load_blk_ready", 0, 64'(blk_ready), 64'd1);
    chk("load_busy", 0, 64'(busy), 64'd1);
    chk("load_done", 0, 64'(done), 64'd0);
    chk("load_wt_valid", 0, 64'(wt_valid), 64'd0);
    for (int i = 0; i < 16; ) begin
      if ($urandom_range(0, 4) == 0) begin
        blk_valid = 1'b0;
        blk_word  = {$urandom, $urandom};
      end else begin
        blk_valid = 1'b1;
        blk_word  = msg[i];
        i++;
      end
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
  endtask

  task automatic expand(input logic hs, input int stall_at, input int abort_at,
                        input bit b2b, input logic b2b_hs);
    int last;
    int n;
    last = hs ? 79 : 63;
    wt_ready = 1'b1;
    for (int t = 0; t <= last; t++) begin
      chk("wt_valid", t, 64'(wt_valid), 64'd1);
      chk("cnt", t, 64'(cnt), 64'(t));
      chk("wt_out", t, wt_out, exp_w[t]);
      chk("blk_ready_exp", t, 64'(blk_ready), 64'd0);
      if (known_v[t]) chk("known_w", t, wt_out, known_w[t]);
      if (t == abort_at) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_blk_ready", t, 64'(blk_ready), 64'd0);
        chk("rst_wt_valid", t, 64'(wt_valid), 64'd0);
        chk("rst_wt_out", t, wt_out, 64'd0);
        chk("rst_cnt", t, 64'(cnt), 64'd0);
        chk("rst_busy", t, 64'(busy), 64'd0);
        chk("rst_done", t, 64'(done), 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_ignored", t, 64'(busy), 64'd0);
        start = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", t, 64'(busy), 64'd0);
        chk("post_rst_done", t, 64'(done), 64'd0);
        return;
      end
      n = (t == stall_at) ? 5 : (($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      if (n > 0) begin
        wt_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
          blk_valid = 1'b1;
          blk_word  = {$urandom, $urandom};
          start     = (k == 0);
          hash_size = ~hs;
          @(posedge clk); #1;
          chk("hold_cnt", t, 64'(cnt), 64'(t));
          chk("hold_wt_out", t, wt_out, exp_w[t]);
          chk("hold_wt_valid", t, 64'(wt_valid), 64'd1);
          chk("hold_busy", t, 64'(busy), 64'd1);
        end
        blk_valid = 1'b0;
        start     = 1'b0;
        wt_ready  = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", last, 64'(done), 64'd1);
    chk("done_wt_valid", last, 64'(wt_valid), 64'd0);
    chk("done_busy", last, 64'(busy), 64'd0);
    if (b2b) begin
      hash_size = b2b_hs;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (!b2b) begin
      chk("done_one_cycle", last, 64'(done), 64'd0);
      chk("idle_busy", last, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    hash_size = 1'b0;
    start     = 1'b0;
    blk_valid = 1'b0;
    blk_word  = 64'd0;
    wt_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_blk_ready", 0, 64'(blk_ready), 64'd0);
    chk("reset_wt_valid", 0, 64'(wt_valid), 64'd0);
    chk("reset_wt_out", 0, wt_out, 64'd0);
    chk("reset_cnt", 0, 64'(cnt), 64'd0);
    chk("reset_busy", 0, 64'(busy), 64'd0);
    chk("reset_done", 0, 64'(done), 64'd0);
    resetn = 1'b1;

    // blk_valid in IDLE must not be taken
    blk_valid = 1'b1;
    blk_word  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    chk("idle_blk_ready", 0, 64'(blk_ready), 64'd0);
    chk("idle_busy0", 0, 64'(busy), 64'd0);
    blk_valid = 1'b0;

    // all-zero block, 256
    clear_block();
    for (int t = 0; t < 64; t++) begin known_v[t] = 1'b1; known_w[t] = 64'd0; end
    compute_model(1'b0);
    load_block(1'b0, 1'b0);
    expand(1'b0, -1, -1, 1'b0, 1'b0);

    // sig0, 256
    clear_block();
    msg[1] = 64'd1;
    known_v[16] = 1'b1; known_w[16] = 64'h0000_0000_0200_4000;
    compute_model(1'b0);
    load_block(1'b0, 1'b0);
    expand(1'b0, -1, -1, 1'b0, 1'b0);

    // sig0, 512
    clear_block();
    msg[1] = 64'd1;
    known_v[16] = 1'b1; known_w[16] = 64'h8100_0000_0000_0000;
    compute_model(1'b1);
    load_block(1'b1, 1'b0);
    expand(1'b1, -1, -1, 1'b0, 1'b0);

    // sig1, 256, then back-to-back start on the done cycle
    clear_block();
    msg[0] = 64'd1;
    known_v[16] = 1'b1; known_w[16] = 64'd1;
    known_v[17] = 1'b1; known_w[17] = 64'd0;
    known_v[18] = 1'b1; known_w[18] = 64'h0000_0000_0000_A000;
    compute_model(1'b0);
    load_block(1'b0, 1'b0);
    expand(1'b0, -1, -1, 1'b1, 1'b1);

    // sig1, 512, entered back-to-back
    clear_block();
    msg[0] = 64'd1;
    known_v[18] = 1'b1; known_w[18] = 64'h0000_2000_0000_0008;
    compute_model(1'b1);
    load_block(1'b1, 1'b1);
    expand(1'b1, -1, -1, 1'b0, 1'b0);

    // "abc", 256, junk upper halves, 5-cycle stall at t=20
    clear_block();
    for (int i = 0; i < 16; i++) msg[i] = 64'hFFFF_FFFF_0000_0000;
    msg[0]  = 64'hFFFF_FFFF_6162_6380;
    msg[15] = 64'hFFFF_FFFF_0000_0018;
    known_v[0]  = 1'b1; known_w[0]  = 64'h0000_0000_6162_6380;
    known_v[16] = 1'b1; known_w[16] = 64'h0000_0000_6162_6380;
    known_v[17] = 1'b1; known_w[17] = 64'h0000_0000_000F_0000;
    compute_model(1'b0);
    load_block(1'b0, 1'b0);
    expand(1'b0, 20, -1, 1'b0, 1'b0);

    // random blocks in both modes
    for (int b = 0; b < 4; b++) begin
      logic hs;
      hs = b[0];
      clear_block();
      for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
      compute_model(hs);
      load_block(hs, 1'b0);
      expand(hs, int'($urandom_range(0, 60)), -1, 1'b0, 1'b0);
    end

    // reset at t=40, then a fresh block
    clear_block();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    compute_model(1'b1);
    load_block(1'b1, 1'b0);
    expand(1'b1, -1, 40, 1'b0, 1'b0);

    clear_block();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    compute_model(1'b0);
    load_block(1'b0, 1'b0);
    expand(1'b0, 30, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_msg_sched.md
Name: sha_msg_sched

Overview:
- Message-schedule stage for the shared SHA-256/384/512 engine.
- Accepts one 16-word message block and streams the W_t sequence to the compression round datapath.
- Each W_t is emitted with its round index cnt; cnt drives the round-constant lookups.
- Covers t=0..63 for SHA-256 and t=0..79 for SHA-384/512; words are 32-bit or 64-bit accordingly.

Parameters:
- NWORDS, 16, depth of the circular schedule buffer. Fixed by the algorithm; not to be overridden.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- hash_size  input  1  0=SHA-256 (32-bit words, 64 rounds); 1=SHA-384/512 (64-bit words, 80 rounds). Sampled on start.
- start  input  1  begin a block; honoured only in IDLE
- blk_valid  input  1  blk_word is valid
- blk_ready  output  1  schedule accepts blk_word this cycle
- blk_word  input  64  message word M_i, big-endian word order, i=0..15. Upper 32 bits ignored in 256 mode.
- wt_valid  output  1  wt_out/cnt are valid
- wt_ready  input  1  downstream consumes the current W_t
- wt_out  output  64  W_t. Upper 32 bits are 0 in 256 mode.
- cnt  output  7  round index t associated with wt_out
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final W_t handshake

Behaviour:
- Reset (async assert, sync deassert domain):
  - state=IDLE.
  - All outputs 0: blk_ready, wt_valid, wt_out, cnt, busy, done.
  - Buffer contents are don't-care.
- States: IDLE -> LOAD -> EXPAND -> IDLE.
- IDLE:
  - start=1 latches hash_size into hs_q, clears the load index, and moves to LOAD.
  - blk_valid is ignored in IDLE.
- LOAD:
  - blk_ready=1.
  - Each cycle with blk_valid & blk_ready writes the word, masked to 32 bits if hs_q=0, into buf[i] and increments i.
  - After the 16th handshake: blk_ready drops the next cycle, t=0, state goes to EXPAND.
  - wt_valid rises the cycle after the 16th handshake, presenting W_0 with cnt=0.
- EXPAND, output register:
  - wt_out/cnt/wt_valid are registered.
  - While wt_valid & !wt_ready, wt_out and cnt hold stable.
  - On a handshake, the next W_t is presented the following cycle. This gives full throughput of one W_t per cycle under continuous wt_ready.
- Word generation:
  - t<16: W_t = buf[t].
  - t>=16: W_t = sig1(W_{t-2}) + W_{t-7} + sig0(W_{t-15}) + W_{t-16}.
  - Addition is modulo 2^32 (hs_q=0) or 2^64 (hs_q=1). Carries beyond the word width are discarded.
  - The result is written to buf[t mod 16], overwriting W_{t-16}. Buffer indices wrap modulo 16.
- Sigma functions:
  - hs_q=0: sig0 = ROTR7 ^ ROTR18 ^ SHR3; sig1 = ROTR17 ^ ROTR19 ^ SHR10 (32-bit).
  - hs_q=1: sig0 = ROTR1 ^ ROTR8 ^ SHR7; sig1 = ROTR19 ^ ROTR61 ^ SHR6 (64-bit).
- Termination:
  - Last round index is 63 (hs_q=0) or 79 (hs_q=1).
  - On the handshake of the last index: wt_valid=0 next cycle, done=1 for exactly one cycle, busy=0, state=IDLE.
- cnt range: cnt never exceeds 63 in 256 mode or 79 in 512 mode. It increments by exactly 1 per handshake with no gaps.
- Ignored inputs:
  - start while busy=1 is ignored.
  - A hash_size change mid-block has no effect.
  - blk_valid outside LOAD is ignored.
- Back-to-back blocks: start may be asserted in the same cycle done is high. Since state is IDLE that cycle, the new block enters LOAD on the next edge.
- Reset mid-operation: resetn low at any point returns to the reset values immediately; no done pulse is produced.

Test Plan:
- Zero block, 256 mode: start, 16 words of 0 -> 64 handshakes, all wt_out=0, cnt 0..63 sequential, done pulse one cycle after cnt=63 handshake.
- sig0 check: W1=1, others 0.
  - 256 mode -> W16=0x02004000.
  - 512 mode -> W16=0x8100000000000000.
  - 512 mode: 80 words, done after cnt=79.
- sig1 check: W0=1, others 0.
  - 256 mode -> W16=1, W17=0, W18=0x0000A000.
  - 512 mode -> W18=0x0000200000000008.
- FIPS "abc" block, 256 mode: W0=0x61626380, W15=0x00000018 -> W16=0x61626380, W17=0x000F0000. blk_word upper bits set to 0xFFFFFFFF are ignored.
- Backpressure: during EXPAND hold wt_ready=0 for 5 cycles at cnt=20 -> wt_out/cnt stable, no index skipped; blk_valid pulses during EXPAND are not accepted.
- Reset and restart:
  - resetn low at cnt=40 -> all outputs 0 asynchronously.
  - start asserted while busy -> ignored.
  - After reset, a fresh block completes normally.
